// File: rtl/reg_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : reg_wr_sched
// Brief    : Write-port scheduler for a 2**PW x 8 register file. Arbitrates
//            ALU writeback (A) and load return (B) round-robin, and runs a
//            sequential zeroing pass on reset or on command.
// Revision : 1.0 - initial release
// ============================================================================
module reg_wr_sched #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_start,
    input  logic          a_valid,
    input  logic [PW:0]   a_addr,
    input  logic [7:0]    a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [PW:0]   b_addr,
    input  logic [7:0]    b_data,
    output logic          b_ready,
    output logic          wr_en,
    output logic [PW:0]   wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy,
    output logic          oob_err
);

    typedef enum logic [0:0] {
        CLR = 1'b0,
        ARB = 1'b1
    } state_t;

    localparam logic          WIN_A   = 1'b0;
    localparam logic          WIN_B   = 1'b1;
    localparam logic [PW-1:0] CNT_MAX = '1;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] cnt;
    logic          last_win;
    logic          conflict;
    logic          accept;
    logic [PW:0]   acc_addr;
    logic [7:0]    acc_data;

    // Next-state and grant logic; ready only ever asserts for one side.
    always_comb begin
        state_nx = state;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        conflict = 1'b0;
        case (state)
            CLR: begin
                if (cnt == CNT_MAX) begin
                    state_nx = ARB;
                end
            end
            ARB: begin
                if (clr_start) begin
                    state_nx = CLR;
                end else if (a_valid && b_valid) begin
                    conflict = 1'b1;
                    if (last_win == WIN_B) begin
                        a_ready = 1'b1;
                    end else begin
                        b_ready = 1'b1;
                    end
                end else begin
                    a_ready = a_valid;
                    b_ready = b_valid;
                end
            end
            default: begin
                state_nx = CLR;
            end
        endcase
    end

    assign accept   = a_ready | b_ready;
    assign acc_addr = a_ready ? a_addr : b_addr;
    assign acc_data = a_ready ? a_data : b_data;
    assign busy     = (state == CLR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLR;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            last_win <= WIN_B;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
            oob_err  <= 1'b0;
        end else if (state == CLR) begin
            // Counter wraps to zero on the final step, ready for the next pass.
            wr_en   <= 1'b1;
            wr_addr <= {1'b0, cnt};
            wr_data <= 8'h00;
            cnt     <= cnt + 1'b1;
        end else if (clr_start) begin
            wr_en <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            wr_en   <= ~acc_addr[PW];
            wr_addr <= acc_addr;
            wr_data <= acc_data;
            if (acc_addr[PW]) begin
                oob_err <= 1'b1;
            end
            if (conflict) begin
                last_win <= a_ready ? WIN_A : WIN_B;
            end
        end else begin
            wr_en <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_wr_sched
// Brief    : Scoreboard bench for reg_wr_sched with directed and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_wr_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr_start = 1'b0;
    logic       a_valid = 1'b0;
    logic [4:0] a_addr = '0;
    logic [7:0] a_data = '0;
    logic       a_ready;
    logic       b_valid = 1'b0;
    logic [4:0] b_addr = '0;
    logic [7:0] b_data = '0;
    logic       b_ready;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       oob_err;

    reg_wr_sched #(.PW(4)) dut (
        .clk(clk), .reset(reset), .clr_start(clr_start),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic       en;
        logic [4:0] addr;
        logic [7:0] data;
        logic       busy;
        logic       oob;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: clear writes remaining, last conflict winner, held outputs.
    int         m_clr_left;
    logic       m_last_b;
    logic [4:0] m_addr;
    logic [7:0] m_data;
    logic       m_oob;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && q.size() > 0 && q[0].t == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("wr_en",   32'(wr_en),   32'(e.en));
            chk("wr_addr", 32'(wr_addr), 32'(e.addr));
            chk("wr_data", 32'(wr_data), 32'(e.data));
            chk("busy",    32'(busy),    32'(e.busy));
            chk("oob_err", 32'(oob_err), 32'(e.oob));
        end
    end

    // Drive one cycle of inputs, predict the grant and the post-edge outputs.
    task automatic step(input logic av, input logic [4:0] aa, input logic [7:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [7:0] bd,
                        input logic clr, output logic ga, output logic gb);
        exp_t e;
        logic ea;
        logic eb;
        logic [4:0] sel;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        clr_start = clr;
        #1;
        ea = 1'b0;
        eb = 1'b0;
        e.t = cyc + 1;
        if (m_clr_left > 0) begin
            e.en = 1'b1;
            m_addr = 5'(16 - m_clr_left);
            m_data = 8'h00;
            m_clr_left--;
            e.busy = (m_clr_left > 0);
        end else if (clr) begin
            e.en = 1'b0;
            m_clr_left = 16;
            e.busy = 1'b1;
        end else begin
            if (av && bv) begin
                if (m_last_b) ea = 1'b1; else eb = 1'b1;
                m_last_b = eb;
            end else begin
                ea = av;
                eb = bv;
            end
            e.en = 1'b0;
            if (ea || eb) begin
                sel = ea ? aa : ba;
                m_addr = sel;
                m_data = ea ? ad : bd;
                e.en = !sel[4];
                if (sel[4]) m_oob = 1'b1;
            end
            e.busy = 1'b0;
        end
        e.addr = m_addr;
        e.data = m_data;
        e.oob = m_oob;
        chk("a_ready", 32'(a_ready), 32'(ea));
        chk("b_ready", 32'(b_ready), 32'(eb));
        q.push_back(e);
        ga = ea;
        gb = eb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        clr_start = 1'b0;
        #1;
        chk("rst_wr_en",   32'(wr_en),   32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_oob_err", 32'(oob_err), 32'd0);
        chk("rst_busy",    32'(busy),    32'd1);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        q.delete();
        m_clr_left = 16;
        m_last_b = 1'b1;
        m_addr = '0;
        m_data = '0;
        m_oob = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic       ga, gb;
    logic       pav, pbv;
    logic [4:0] paa, pba;
    logic [7:0] pad, pbd;
    logic [7:0] da, db;

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return 5'(16 + $urandom_range(0, 15));
        return 5'($urandom_range(0, 15));
    endfunction

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // A holds addr 3 through the clear pass, then writes 4 back-to-back.
        ga = 1'b0;
        for (int i = 0; i < 40 && !ga; i++) step(1, 5'd3, 8'h5A, 0, 5'd0, 8'h00, 0, ga, gb);
        step(1, 5'd4, 8'h6B, 0, 5'd0, 8'h00, 0, ga, gb);

        // Both valid with fresh data on every accept.
        da = 8'h30;
        db = 8'h40;
        for (int i = 0; i < 4; i++) begin
            step(1, 5'd8, da, 1, 5'd9, db, 0, ga, gb);
            if (ga) da++;
            if (gb) db++;
        end

        // Same-address conflict, then the loser alone.
        step(1, 5'd7, 8'h11, 1, 5'd7, 8'h22, 0, ga, gb);
        step(0, 5'd0, 8'h00, 1, 5'd7, 8'h22, 0, ga, gb);

        // Out-of-range write from B.
        step(0, 5'd0, 8'h00, 1, 5'h10, 8'hFF, 0, ga, gb);
        step(0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 0, ga, gb);

        // Clear command alongside a valid A, which is accepted after the pass.
        step(1, 5'd5, 8'h77, 0, 5'd0, 8'h00, 1, ga, gb);
        ga = 1'b0;
        for (int i = 0; i < 40 && !ga; i++) step(1, 5'd5, 8'h77, 0, 5'd0, 8'h00, 0, ga, gb);

        // Reset in the middle of a clear pass.
        step(0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 1, ga, gb);
        for (int i = 0; i < 5; i++) step(0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 0, ga, gb);
        do_reset();
        for (int i = 0; i < 18; i++) step(0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 0, ga, gb);

        // Random traffic; a requester keeps its request until granted.
        pav = 1'b0;
        pbv = 1'b0;
        paa = '0; pba = '0; pad = '0; pbd = '0;
        for (int i = 0; i < 500; i++) begin
            if (!pav && $urandom_range(0, 2) != 0) begin
                pav = 1'b1; paa = rnd_addr(); pad = 8'($urandom);
            end
            if (!pbv && $urandom_range(0, 2) != 0) begin
                pbv = 1'b1; pba = rnd_addr(); pbd = 8'($urandom);
            end
            step(pav, paa, pad, pbv, pba, pbd, ($urandom_range(0, 79) == 0), ga, gb);
            if (ga) pav = 1'b0;
            if (gb) pbv = 1'b0;
        end
        step(0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 0, ga, gb);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_wr_sched.md
# reg_wr_sched

Write-port scheduler for the 16-entry, 8-bit register file. It shares the file's single write port between two requesters: A is ALU writeback and B is load-return data. On reset, and again on command, it runs a sequential clear pass that zeroes every register. It drives `wr_en` / `wr_addr` / `dat_in` of the register file from registered outputs, and sits between the execute/memory stages and the register file.

## Interface
Parameters:
- `PW`, default 4 — register pointer width; the file holds 2**PW entries and the address ports are PW+1 bits wide.

Ports:
- `clk` — in, 1 — single clock; all state changes on the rising edge.
- `reset` — in, 1 — asynchronous, active-high.
- `clr_start` — in, 1 — request a full clear pass; sampled in ARB only.
- `a_valid` — in, 1 — requester A has a write.
- `a_addr` — in, PW+1 — requester A destination.
- `a_data` — in, 8 — requester A write data.
- `a_ready` — out, 1 — A accepted this cycle when `a_valid & a_ready`.
- `b_valid`, `b_addr`, `b_data`, `b_ready` — same as A, for requester B.
- `wr_en` — out, 1 — register file write enable (registered).
- `wr_addr` — out, PW+1 — register file write address (registered).
- `wr_data` — out, 8 — register file write data (registered).
- `busy` — out, 1 — a clear pass is in progress (state == CLR).
- `oob_err` — out, 1 — sticky; set when an accepted address has bit PW = 1.

## Operation
- States: CLR and ARB. `reset` forces CLR with clear counter `cnt` = 0.
- CLR:
  - Each edge registers `wr_en`=1, `wr_addr`={0,cnt}, `wr_data`=0, then increments `cnt`.
  - On the edge where `cnt` == 2**PW-1, go to ARB.
  - `a_ready` = `b_ready` = 0 throughout.
  - `clr_start` is ignored.
- ARB, ready logic (combinational):
  - If `clr_start`=1: both ready = 0, and the next state is CLR with `cnt`=0.
  - Otherwise, if only one requester is valid, it is ready.
  - Otherwise, if both are valid, the winner is chosen round-robin; the loser's ready = 0 and it must hold valid/addr/data stable.
  - Ready is never 1 for both in the same cycle.
- Round-robin: 1-bit `last_win` flop, reset to B so A wins the first conflict. It updates only on conflict cycles, to the winner. Non-conflict grants do not change it.
- Accepted request in ARB:
  - Next edge registers `wr_en` = ~addr[PW], `wr_addr`=addr, `wr_data`=data.
  - If addr[PW]=1, the request is consumed (ready handshake completes), no write occurs, and `oob_err` is set.
  - `oob_err` clears only on `reset`.
- No accept in ARB: next edge registers `wr_en`=0; `wr_addr`/`wr_data` hold.
- Same-address conflict: the winner writes first and the loser writes the following cycle, so the loser's data is final. No merging.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `oob_err`=0, state=CLR, `cnt`=0, `last_win`=B. Combinationally this gives `busy`=1 and `a_ready`=`b_ready`=0.
- Clear pass:
  - Edges k=0..2**PW-1 after reset release register `wr_en`=1, `wr_addr`=k.
  - The register file captures address k at edge k+1.
  - `busy` falls after edge 2**PW-1; with PW=4 it is high for exactly 16 cycles.
  - The first handshake is possible at edge 16.
- Request latency: accept at edge n puts the write on the outputs during cycle n→n+1, and the register file captures it at edge n+1.
- Throughput: one write per cycle, back-to-back, with no bubbles.
- `clr_start` in ARB at edge n: no accept at n, `wr_en`=0 in cycle n→n+1, clear writes at edges n+1..n+16, back in ARB after edge n+16.
- Reset mid-clear or mid-burst: everything returns to reset values immediately. A pending accept that has not yet been written is lost. A new full clear starts on release.

## Test plan
- Release reset → `wr_en`=1 with `wr_addr` 0..15 and `wr_data`=0 on 16 consecutive cycles; `busy`=1 for those 16 cycles; `a_ready`/`b_ready`=0 until `busy`=0.
- After the clear, A alone writes addr 3 with 0x5A → next cycle `wr_en`=1, `wr_addr`=3, `wr_data`=0x5A; then A writes addr 4 back-to-back → the next cycle shows addr 4 with no gap.
- A and B both valid for 4 cycles, with new data each accept → grants A, B, A, B; `a_ready` & `b_ready` are never both 1.
- A and B both target addr 7 (A=0x11, B=0x22), first conflict → writes 0x11 then 0x22; the register file reads 0x22.
- B writes addr 0x10 (bit 4 set) with 0xFF → handshake completes, `wr_en` stays 0, `oob_err`=1 and stays 1 until reset.
- `clr_start` with A valid at the same edge → `a_ready`=0 that cycle, 16 clear writes follow, then A is accepted on the first ARB cycle. Assert `reset` at clear step 5 → outputs return to reset values, and the clear restarts at addr 0 on release.
